// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle RV32I subset core (lw, sw, R, I, beq, jal).
// Outputs decode combinationally from the state; strobes are masked while rst_n is low.
module multicycle_ctrl_fsm #(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       irWrite,
    output logic       pcWrite,
    output logic       regWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_illegal;

    logic w_ready;
    logic w_mem_req;
    logic w_mem_write;
    logic w_ir_write;
    logic w_pc_update;
    logic w_branch;
    logic w_pc_write;
    logic w_reg_write;
    logic w_instr_done;

    assign w_ready = USE_MEM_READY ? mem_ready : 1'b1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sticky trap flag, set on the transition into TRAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else if (w_state_nxt == S_TRAP) begin
            r_illegal <= 1'b1;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_nxt  = r_state;
        w_mem_req    = 1'b0;
        adrSrc       = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_reg_write  = 1'b0;
        resultSrc    = 2'b00;
        aluSrcA      = 2'b00;
        aluSrcB      = 2'b00;
        aluOp        = 2'b00;
        w_instr_done = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                aluSrcB     = 2'b10;
                resultSrc   = 2'b10;
                w_ir_write  = w_ready;
                w_pc_update = w_ready;
                if (w_ready) begin
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: w_state_nxt = S_MEMADR;
                    OP_R:         w_state_nxt = S_EXECR;
                    OP_I:         w_state_nxt = S_EXECI;
                    OP_BEQ:       w_state_nxt = S_BEQ;
                    OP_JAL:       w_state_nxt = S_JAL;
                    default:      w_state_nxt = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                aluSrcA     = 2'b10;
                aluSrcB     = 2'b01;
                w_state_nxt = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                adrSrc    = 1'b1;
                if (w_ready) begin
                    w_state_nxt = S_MEMWB;
                end
            end
            S_MEMWB: begin
                resultSrc    = 2'b01;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_state_nxt  = S_FETCH;
            end
            S_MEMWRITE: begin
                w_mem_req    = 1'b1;
                adrSrc       = 1'b1;
                w_mem_write  = 1'b1;
                w_instr_done = w_ready;
                if (w_ready) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_EXECR: begin
                aluSrcA     = 2'b10;
                aluOp       = 2'b10;
                w_state_nxt = S_ALUWB;
            end
            S_EXECI: begin
                aluSrcA     = 2'b10;
                aluSrcB     = 2'b01;
                aluOp       = 2'b10;
                w_state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_state_nxt  = S_FETCH;
            end
            S_BEQ: begin
                aluSrcA      = 2'b10;
                aluOp        = 2'b01;
                w_branch     = 1'b1;
                w_instr_done = 1'b1;
                w_state_nxt  = S_FETCH;
            end
            S_JAL: begin
                aluSrcA     = 2'b01;
                aluSrcB     = 2'b10;
                w_pc_update = 1'b1;
                w_state_nxt = S_ALUWB;
            end
            S_TRAP: begin
                w_state_nxt = S_TRAP;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase

        w_pc_write = w_pc_update | (w_branch & zero);
    end

    // Strobes are held off while reset is asserted
    assign mem_req    = w_mem_req    & rst_n;
    assign memWrite   = w_mem_write  & rst_n;
    assign irWrite    = w_ir_write   & rst_n;
    assign pcWrite    = w_pc_write   & rst_n;
    assign regWrite   = w_reg_write  & rst_n;
    assign instr_done = w_instr_done & rst_n;
    assign illegal    = r_illegal;
    assign state      = 4'(r_state);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: instruction-level model pushes per-cycle
// expected outputs, a negedge monitor pops and compares against the DUT.
module tb_multicycle_ctrl_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       mreq;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       pcw;
        logic       rw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] aop;
        logic       done;
        logic       ill;
    } obs_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // Per-state static outputs, indexed by the documented state number
    localparam bit       T_MREQ [12] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam bit       T_ADR  [12] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam bit       T_MW   [12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam bit       T_RW   [12] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
    localparam bit [1:0] T_RS   [12] = '{2'd2,2'd0,2'd0,2'd0,2'd1,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0};
    localparam bit [1:0] T_SA   [12] = '{2'd0,2'd1,2'd2,2'd0,2'd0,2'd0,2'd2,2'd2,2'd0,2'd2,2'd1,2'd0};
    localparam bit [1:0] T_SB   [12] = '{2'd2,2'd1,2'd1,2'd0,2'd0,2'd0,2'd0,2'd1,2'd0,2'd0,2'd2,2'd0};
    localparam bit [1:0] T_AOP  [12] = '{2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd2,2'd2,2'd0,2'd1,2'd0,2'd0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, adrSrc, memWrite, irWrite, pcWrite, regWrite, instr_done, illegal;
    logic [1:0] resultSrc, aluSrcA, aluSrcB, aluOp;
    logic [3:0] state;

    obs_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    multicycle_ctrl_fsm #(.USE_MEM_READY(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .adrSrc(adrSrc), .memWrite(memWrite), .irWrite(irWrite),
        .pcWrite(pcWrite), .regWrite(regWrite), .resultSrc(resultSrc),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .instr_done(instr_done), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    function automatic obs_t expect_obs(input int st_in, input bit rdy, input bit z, input bit rstn);
        obs_t e;
        int   s;
        s      = rstn ? st_in : 0;
        e.st   = 4'(s);
        e.mreq = T_MREQ[s];
        e.adr  = T_ADR[s];
        e.mw   = T_MW[s];
        e.rw   = T_RW[s];
        e.rs   = T_RS[s];
        e.sa   = T_SA[s];
        e.sb   = T_SB[s];
        e.aop  = T_AOP[s];
        e.irw  = (s == 0) && rdy;
        e.pcw  = ((s == 0) && rdy) || (s == 10) || ((s == 9) && z);
        e.done = (s == 4) || (s == 8) || (s == 9) || ((s == 5) && rdy);
        e.ill  = (s == 11);
        if (!rstn) begin
            {e.mreq, e.mw, e.irw, e.pcw, e.rw, e.done} = 6'b0;
        end
        return e;
    endfunction

    // One clock cycle: drive inputs, queue the expected observation, advance
    task automatic cyc(input int st, input bit rdy, input bit rstn, input int zf);
        bit z;
        z = (zf < 0) ? 1'($urandom_range(0, 1)) : (zf != 0);
        mem_ready = rdy;
        zero      = z;
        rst_n     = rstn;
        sb_q.push_back(expect_obs(st, rdy, z, rstn));
        @(posedge clk);
        #1;
    endtask

    // Instruction-level model: state path per class, stalls on memory phases, optional reset abort
    task automatic run_instr(input logic [6:0] o, input int sf, input int sm, input int zf, input int abort_idx);
        int path[$];
        int n;
        bit mem_phase;
        case (o)
            OP_LW:   path = '{0, 1, 2, 3, 4};
            OP_SW:   path = '{0, 1, 2, 5};
            OP_R:    path = '{0, 1, 6, 8};
            OP_I:    path = '{0, 1, 7, 8};
            OP_BEQ:  path = '{0, 1, 9};
            OP_JAL:  path = '{0, 1, 10, 8};
            default: path = '{0, 1, 11};
        endcase
        op = o;
        foreach (path[i]) begin
            mem_phase = (path[i] == 0) || (path[i] == 3) || (path[i] == 5);
            n = !mem_phase ? 0 : ((path[i] == 0) ? sf : sm);
            if (i == abort_idx) begin
                repeat (n) cyc(path[i], 1'b0, 1'b1, zf);
                cyc(0, 1'b1, 1'b0, -1);
                return;
            end
            if (path[i] == 11) begin
                repeat (20) cyc(11, 1'($urandom_range(0, 1)), 1'b1, -1);
                cyc(0, 1'b0, 1'b0, -1);
            end else if (mem_phase) begin
                repeat (n) cyc(path[i], 1'b0, 1'b1, zf);
                cyc(path[i], 1'b1, 1'b1, zf);
            end else begin
                cyc(path[i], 1'($urandom_range(0, 1)), 1'b1, zf);
            end
        end
    endtask

    // Monitor: compare every observed cycle against the queued expectation
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            obs_t e;
            obs_t g;
            e = sb_q.pop_front();
            g = '{state, mem_req, adrSrc, memWrite, irWrite, pcWrite, regWrite,
                  resultSrc, aluSrcA, aluSrcB, aluOp, instr_done, illegal};
            n_chk++;
            if (g === e) begin
                n_pass++;
            end else begin
                $display("FAIL obs t=%0t op=%b got st=%0d vec=%h exp st=%0d vec=%h",
                         $time, op, g.st, g, e.st, e);
            end
        end
    end

    initial begin
        logic [6:0] ops [10];
        logic [6:0] o;
        int         ab;
        ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, 7'b1110011, OP_LW, OP_R, OP_BEQ};

        @(posedge clk);
        #1;
        repeat (3) cyc(0, 1'b1, 1'b0, -1);

        run_instr(OP_LW, 0, 0, -1, -1);
        run_instr(OP_SW, 0, 3, -1, -1);
        run_instr(OP_BEQ, 0, 0, 1, -1);
        run_instr(OP_BEQ, 0, 0, 0, -1);
        run_instr(OP_R, 0, 0, -1, -1);
        run_instr(OP_I, 0, 0, -1, -1);
        run_instr(OP_JAL, 0, 0, -1, -1);
        run_instr(7'b1110011, 0, 0, -1, -1);
        // Reset during a fetch stall
        cyc(0, 1'b0, 1'b1, -1);
        cyc(0, 1'b0, 1'b1, -1);
        cyc(0, 1'b0, 1'b0, -1);
        run_instr(OP_LW, 2, 2, -1, -1);
        // Reset while a store is stalled drops the write
        run_instr(OP_SW, 1, 2, -1, 3);
        run_instr(OP_LW, 0, 0, -1, 3);

        for (int k = 0; k < 200; k++) begin
            o = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 15) == 0) begin
                o = 7'($urandom);
            end
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : -1;
            run_instr(o, $urandom_range(0, 2), $urandom_range(0, 3), -1, ab);
        end

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain got=%0d pending, need 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
